// File: rtl/game_io_hub.sv
// -----------------------------------------------------------------------------
// game_io_hub
//   Memory-mapped I/O hub that sits between the processor data-memory port and
//   the game peripherals. It decodes one-hot direction keys, holds the player
//   position registers, detects player/pickup box overlap, runs one powerup
//   timer per player and respawns collected pickups after a parking delay.
//
// Ports
//   clock, reset     rising-edge clock, asynchronous active-low reset
//   addr, wr_data    processor address / store data
//   wren             processor store enable
//   dmem_q           data-memory read data
//   dmem_wren        store enable forwarded to data memory (RAM window only)
//   proc_data_in     registered read data returned to the processor
//   dir_keys         {left,down,right,up} per player, player 0 in [3:0]
//   player_x/y       flattened player positions, player 0 in [31:0]
//   powerup_x/y      flattened live pickup positions (all ones = parked)
//   powerup_active   per-player powerup flag
// -----------------------------------------------------------------------------
module game_io_hub #(
   parameter int NUM_PLAYERS     = 2,
   parameter int NUM_POWERUPS    = 1,
   parameter int RAM_WORDS       = 4096,
   parameter int INPUT_BASE      = 4100,
   parameter int PLAYER_BASE     = 4200,
   parameter int PU_BASE         = 4300,
   parameter int SPRITE_W        = 32,
   parameter int SPRITE_H        = 32,
   parameter int TICKS_PER_STAGE = 100000000,
   parameter int NUM_STAGES      = 7,
   parameter int RESPAWN_CYCLES  = 500000000
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [16:0]                 addr,
   input  logic [31:0]                 wr_data,
   input  logic                        wren,
   input  logic [31:0]                 dmem_q,
   output logic                        dmem_wren,
   output logic [31:0]                 proc_data_in,
   input  logic [4*NUM_PLAYERS-1:0]    dir_keys,
   output logic [32*NUM_PLAYERS-1:0]   player_x,
   output logic [32*NUM_PLAYERS-1:0]   player_y,
   output logic [32*NUM_POWERUPS-1:0]  powerup_x,
   output logic [32*NUM_POWERUPS-1:0]  powerup_y,
   output logic [NUM_PLAYERS-1:0]      powerup_active
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } tmr_state_e;

   localparam logic [31:0] RAM_LIMIT  = 32'(RAM_WORDS);
   localparam logic [31:0] TICK_LAST  = 32'(TICKS_PER_STAGE - 1);
   localparam logic [31:0] STAGE_LAST = 32'(NUM_STAGES - 1);
   localparam logic [31:0] RESP_LAST  = 32'(RESPAWN_CYCLES - 1);
   localparam logic [31:0] PARKED_POS = 32'hFFFF_FFFF;

   // Player state
   logic [31:0] px_q    [NUM_PLAYERS];
   logic [31:0] px_d    [NUM_PLAYERS];
   logic [31:0] py_q    [NUM_PLAYERS];
   logic [31:0] py_d    [NUM_PLAYERS];
   tmr_state_e  state_q [NUM_PLAYERS];
   tmr_state_e  state_d [NUM_PLAYERS];
   logic [31:0] tick_q  [NUM_PLAYERS];
   logic [31:0] tick_d  [NUM_PLAYERS];
   logic [31:0] stage_q [NUM_PLAYERS];
   logic [31:0] stage_d [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0] flag_q;
   logic [NUM_PLAYERS-1:0] flag_d;

   // Pickup state: home position, live position, respawn countdown
   logic [31:0] hx_q   [NUM_POWERUPS];
   logic [31:0] hx_d   [NUM_POWERUPS];
   logic [31:0] hy_q   [NUM_POWERUPS];
   logic [31:0] hy_d   [NUM_POWERUPS];
   logic [31:0] ux_q   [NUM_POWERUPS];
   logic [31:0] ux_d   [NUM_POWERUPS];
   logic [31:0] uy_q   [NUM_POWERUPS];
   logic [31:0] uy_d   [NUM_POWERUPS];
   logic [31:0] resp_q [NUM_POWERUPS];
   logic [31:0] resp_d [NUM_POWERUPS];
   logic [NUM_POWERUPS-1:0] parked_q;
   logic [NUM_POWERUPS-1:0] parked_d;

   logic [31:0] rdata_q;
   logic [31:0] rdata_d;

   logic [31:0]             addr_ext_s;
   logic [NUM_PLAYERS-1:0]  player_hit_s;
   logic [NUM_POWERUPS-1:0] pu_hit_s;

   // One-hot key vector to direction code; anything not exactly one-hot is 0.
   function automatic logic [31:0] dir_code(input logic [3:0] keys);
      logic [31:0] code;
      case (keys)
         4'b0001: code = 32'd1;
         4'b0010: code = 32'd2;
         4'b0100: code = 32'd3;
         4'b1000: code = 32'd4;
         default: code = 32'd0;
      endcase
      return code;
   endfunction

   // Unsigned box overlap; the sums wrap modulo 2^32 on purpose.
   function automatic logic box_hit(input logic [31:0] px, input logic [31:0] py,
                                    input logic [31:0] ux, input logic [31:0] uy);
      logic [31:0] px_far;
      logic [31:0] py_far;
      logic [31:0] ux_far;
      logic [31:0] uy_far;
      px_far = px + 32'(SPRITE_W);
      py_far = py + 32'(SPRITE_H);
      ux_far = ux + 32'(SPRITE_W);
      uy_far = uy + 32'(SPRITE_H);
      return (px_far >= ux) && (px <= ux_far) && (py_far >= uy) && (py <= uy_far);
   endfunction

   assign addr_ext_s = {15'd0, addr};
   assign dmem_wren  = wren & (addr_ext_s < RAM_LIMIT);

   // Collision arbitration: per pickup, the lowest-index overlapping player wins.
   always_comb begin
      player_hit_s = '0;
      pu_hit_s     = '0;
      for (int k = 0; k < NUM_POWERUPS; k++) begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (!parked_q[k] && !pu_hit_s[k] && box_hit(px_q[p], py_q[p], ux_q[k], uy_q[k])) begin
               pu_hit_s[k]     = 1'b1;
               player_hit_s[p] = 1'b1;
            end else begin
               player_hit_s[p] = player_hit_s[p];
            end
         end
      end
   end

   // Next-state: register writes, powerup timers, pickup park/respawn.
   always_comb begin
      px_d     = px_q;
      py_d     = py_q;
      state_d  = state_q;
      tick_d   = tick_q;
      stage_d  = stage_q;
      flag_d   = flag_q;
      hx_d     = hx_q;
      hy_d     = hy_q;
      ux_d     = ux_q;
      uy_d     = uy_q;
      resp_d   = resp_q;
      parked_d = parked_q;

      for (int p = 0; p < NUM_PLAYERS; p++) begin
         if (wren && (addr_ext_s == 32'(PLAYER_BASE + 3 * p))) begin
            px_d[p] = wr_data;
         end else if (wren && (addr_ext_s == 32'(PLAYER_BASE + 3 * p + 1))) begin
            py_d[p] = wr_data;
         end else begin
            px_d[p] = px_q[p];
         end

         case (state_q[p])
            ST_IDLE: begin
               if (player_hit_s[p]) begin
                  state_d[p] = ST_ACTIVE;
                  tick_d[p]  = 32'd0;
                  stage_d[p] = 32'd0;
                  flag_d[p]  = 1'b1;
               end else begin
                  flag_d[p] = 1'b0;
               end
            end
            ST_ACTIVE: begin
               // A fresh hit restarts the countdown; the flag simply stays high.
               if (player_hit_s[p]) begin
                  tick_d[p]  = 32'd0;
                  stage_d[p] = 32'd0;
                  flag_d[p]  = 1'b1;
               end else if (tick_q[p] == TICK_LAST) begin
                  tick_d[p] = 32'd0;
                  if (stage_q[p] == STAGE_LAST) begin
                     state_d[p] = ST_IDLE;
                     stage_d[p] = 32'd0;
                     flag_d[p]  = 1'b0;
                  end else begin
                     stage_d[p] = stage_q[p] + 32'd1;
                  end
               end else begin
                  tick_d[p] = tick_q[p] + 32'd1;
               end
            end
            default: begin
               state_d[p] = ST_IDLE;
               tick_d[p]  = 32'd0;
               stage_d[p] = 32'd0;
               flag_d[p]  = 1'b0;
            end
         endcase
      end

      for (int k = 0; k < NUM_POWERUPS; k++) begin
         if (wren && (addr_ext_s == 32'(PU_BASE + 2 * k))) begin
            hx_d[k] = wr_data;
         end else if (wren && (addr_ext_s == 32'(PU_BASE + 2 * k + 1))) begin
            hy_d[k] = wr_data;
         end else begin
            hx_d[k] = hx_q[k];
         end

         if (pu_hit_s[k]) begin
            ux_d[k]     = PARKED_POS;
            uy_d[k]     = PARKED_POS;
            parked_d[k] = 1'b1;
            resp_d[k]   = RESP_LAST;
         end else if (parked_q[k]) begin
            // Respawn lands on the home value held at that moment.
            if (resp_q[k] == 32'd0) begin
               ux_d[k]     = hx_q[k];
               uy_d[k]     = hy_q[k];
               parked_d[k] = 1'b0;
            end else begin
               resp_d[k] = resp_q[k] - 32'd1;
            end
         end else if (wren && (addr_ext_s == 32'(PU_BASE + 2 * k))) begin
            ux_d[k] = wr_data;
         end else if (wren && (addr_ext_s == 32'(PU_BASE + 2 * k + 1))) begin
            uy_d[k] = wr_data;
         end else begin
            ux_d[k] = ux_q[k];
         end
      end
   end

   // Read mux: RAM window, then the mapped peripheral registers, else zero.
   always_comb begin
      rdata_d = 32'd0;
      if (addr_ext_s < RAM_LIMIT) begin
         rdata_d = dmem_q;
      end else begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (addr_ext_s == 32'(INPUT_BASE + p)) begin
               rdata_d = dir_code(dir_keys[4*p +: 4]);
            end else if (addr_ext_s == 32'(PLAYER_BASE + 3 * p)) begin
               rdata_d = px_q[p];
            end else if (addr_ext_s == 32'(PLAYER_BASE + 3 * p + 1)) begin
               rdata_d = py_q[p];
            end else if (addr_ext_s == 32'(PLAYER_BASE + 3 * p + 2)) begin
               rdata_d = {31'd0, flag_q[p]};
            end else begin
               rdata_d = rdata_d;
            end
         end
         for (int k = 0; k < NUM_POWERUPS; k++) begin
            if (addr_ext_s == 32'(PU_BASE + 2 * k)) begin
               rdata_d = hx_q[k];
            end else if (addr_ext_s == 32'(PU_BASE + 2 * k + 1)) begin
               rdata_d = hy_q[k];
            end else begin
               rdata_d = rdata_d;
            end
         end
      end
   end

   // State registers; reset restores the starting layout and idles all timers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            px_q[p]    <= 32'(100 + 140 * p);
            py_q[p]    <= 32'(100 + 150 * p);
            state_q[p] <= ST_IDLE;
            tick_q[p]  <= 32'd0;
            stage_q[p] <= 32'd0;
         end
         flag_q <= '0;
         for (int k = 0; k < NUM_POWERUPS; k++) begin
            hx_q[k]   <= 32'd300;
            hy_q[k]   <= 32'(300 + 64 * k);
            ux_q[k]   <= 32'd300;
            uy_q[k]   <= 32'(300 + 64 * k);
            resp_q[k] <= 32'd0;
         end
         parked_q <= '0;
         rdata_q  <= 32'd0;
      end else begin
         px_q     <= px_d;
         py_q     <= py_d;
         state_q  <= state_d;
         tick_q   <= tick_d;
         stage_q  <= stage_d;
         flag_q   <= flag_d;
         hx_q     <= hx_d;
         hy_q     <= hy_d;
         ux_q     <= ux_d;
         uy_q     <= uy_d;
         resp_q   <= resp_d;
         parked_q <= parked_d;
         rdata_q  <= rdata_d;
      end
   end

   // Flatten the register arrays onto the output buses.
   always_comb begin
      player_x  = '0;
      player_y  = '0;
      powerup_x = '0;
      powerup_y = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         player_x[32*p +: 32] = px_q[p];
         player_y[32*p +: 32] = py_q[p];
      end
      for (int k = 0; k < NUM_POWERUPS; k++) begin
         powerup_x[32*k +: 32] = ux_q[k];
         powerup_y[32*k +: 32] = uy_q[k];
      end
   end

   assign powerup_active = flag_q;
   assign proc_data_in   = rdata_q;

endmodule

// File: tb/tb_game_io_hub.sv
// -----------------------------------------------------------------------------
// tb_game_io_hub
//   Directed bench for game_io_hub with short timer/respawn settings
//   (4 ticks per stage, 2 stages, 10 respawn cycles) and two pickups.
// -----------------------------------------------------------------------------
module tb_game_io_hub;

   localparam int NP  = 2;
   localparam int NPU = 2;
   localparam logic [31:0] PARK = 32'hFFFF_FFFF;

   logic              clock;
   logic              reset;
   logic [16:0]       addr;
   logic [31:0]       wr_data;
   logic              wren;
   logic [31:0]       dmem_q;
   logic              dmem_wren;
   logic [31:0]       proc_data_in;
   logic [4*NP-1:0]   dir_keys;
   logic [32*NP-1:0]  player_x;
   logic [32*NP-1:0]  player_y;
   logic [32*NPU-1:0] powerup_x;
   logic [32*NPU-1:0] powerup_y;
   logic [NP-1:0]     powerup_active;

   int checks_cnt;
   int fail_cnt;

   game_io_hub #(
      .NUM_PLAYERS(NP), .NUM_POWERUPS(NPU),
      .TICKS_PER_STAGE(4), .NUM_STAGES(2), .RESPAWN_CYCLES(10)
   ) dut (
      .clock(clock), .reset(reset), .addr(addr), .wr_data(wr_data), .wren(wren),
      .dmem_q(dmem_q), .dmem_wren(dmem_wren), .proc_data_in(proc_data_in),
      .dir_keys(dir_keys), .player_x(player_x), .player_y(player_y),
      .powerup_x(powerup_x), .powerup_y(powerup_y), .powerup_active(powerup_active)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic set_wr(input logic [16:0] a, input logic [31:0] d);
      wren    = 1'b1;
      addr    = a;
      wr_data = d;
   endtask

   initial begin
      checks_cnt = 0;
      fail_cnt   = 0;
      reset      = 1'b0;
      addr       = 17'd0;
      wr_data    = 32'd0;
      wren       = 1'b0;
      dmem_q     = 32'd0;
      dir_keys   = 8'h00;
      step(2);
      reset = 1'b1;
      step(1);

      // Reset layout
      check_val("rst_p0x", player_x[31:0], 32'd100);
      check_val("rst_p0y", player_y[31:0], 32'd100);
      check_val("rst_p1x", player_x[63:32], 32'd240);
      check_val("rst_p1y", player_y[63:32], 32'd250);
      check_val("rst_u0x", powerup_x[31:0], 32'd300);
      check_val("rst_u0y", powerup_y[31:0], 32'd300);
      check_val("rst_u1y", powerup_y[63:32], 32'd364);
      check_val("rst_rd", proc_data_in, 32'd0);
      check_val("rst_flag", {30'd0, powerup_active}, 32'd0);

      // Direction decode
      dir_keys = 8'h01; addr = 17'd4100; step(1);
      check_val("dir_up", proc_data_in, 32'd1);
      dir_keys = 8'h09; step(1);
      check_val("dir_two", proc_data_in, 32'd0);
      dir_keys = 8'h80; addr = 17'd4101; step(1);
      check_val("dir_p1_left", proc_data_in, 32'd4);
      dir_keys = 8'h40; step(1);
      check_val("dir_p1_down", proc_data_in, 32'd3);
      dir_keys = 8'h00;

      // RAM and peripheral reads, write gating
      addr = 17'd5; dmem_q = 32'hDEAD_BEEF; step(1);
      check_val("rd_dmem", proc_data_in, 32'hDEAD_BEEF);
      addr = 17'd4203; step(1);
      check_val("rd_p1x", proc_data_in, 32'd240);
      addr = 17'd4301; step(1);
      check_val("rd_h0y", proc_data_in, 32'd300);
      set_wr(17'd100, 32'd7); #1;
      check_val("wren_ram", {31'd0, dmem_wren}, 32'd1);
      step(1);
      set_wr(17'd5000, 32'd7); #1;
      check_val("wren_unmapped", {31'd0, dmem_wren}, 32'd0);
      step(1);
      set_wr(17'd4202, 32'd1); #1;
      check_val("wren_ro", {31'd0, dmem_wren}, 32'd0);
      step(1);
      wren = 1'b0; addr = 17'd5000; step(1);
      check_val("rd_unmapped", proc_data_in, 32'd0);
      addr = 17'd4202; step(1);
      check_val("ro_ignored", proc_data_in, 32'd0);

      // p0 onto pickup0: park + flag on edge E0
      set_wr(17'd4200, 32'd268); step(1);
      set_wr(17'd4201, 32'd300); step(1);
      wren = 1'b0; addr = 17'd4202; step(1);               // E0
      check_val("hit_u0x", powerup_x[31:0], PARK);
      check_val("hit_u0y", powerup_y[31:0], PARK);
      check_val("hit_u1x", powerup_x[63:32], 32'd300);
      check_val("hit_flag", {30'd0, powerup_active}, 32'd1);
      step(1);                                             // E1
      check_val("rd_flag", proc_data_in, 32'd1);
      step(6);                                             // E7
      check_val("flag_e7", {30'd0, powerup_active}, 32'd1);
      step(1);                                             // E8
      check_val("flag_e8", {30'd0, powerup_active}, 32'd0);
      step(1);                                             // E9
      check_val("park_e9", powerup_x[31:0], PARK);
      step(1);                                             // E10
      check_val("resp_u0x", powerup_x[31:0], 32'd300);
      check_val("resp_u0y", powerup_y[31:0], 32'd300);
      step(1);                                             // H = E11, p0 still on it
      check_val("rehit_u0x", powerup_x[31:0], PARK);
      check_val("rehit_flag", {30'd0, powerup_active}, 32'd1);

      // Re-hit during stage 1 (pickup1) restarts the timer
      step(4);                                             // H+4
      set_wr(17'd4201, 32'd364); step(1);                  // H+5
      set_wr(17'd4203, 32'd268); step(1);                  // H+6
      check_val("u1_parked", powerup_x[63:32], PARK);
      check_val("restart_flag", {30'd0, powerup_active}, 32'd1);
      set_wr(17'd4204, 32'd364); step(1);                  // H+7
      wren = 1'b0; step(1);                                // H+8
      check_val("flag_h8", {30'd0, powerup_active}, 32'd1);
      step(5);                                             // H+13
      check_val("flag_h13", {30'd0, powerup_active}, 32'd1);
      step(1);                                             // H+14
      check_val("flag_h14", {30'd0, powerup_active}, 32'd0);
      step(1);                                             // H+15
      check_val("u1_park_h15", powerup_x[63:32], PARK);
      step(1);                                             // H+16
      check_val("u1_back_x", powerup_x[63:32], 32'd300);
      check_val("u1_back_y", powerup_y[63:32], 32'd364);
      check_val("u0_live", powerup_x[31:0], 32'd300);
      step(1);                                             // H+17: both on pickup1
      check_val("tie_u1", powerup_x[63:32], PARK);
      check_val("tie_flag", {30'd0, powerup_active}, 32'd1);

      // Home write moves a live pickup at once
      set_wr(17'd4300, 32'd500); step(1);
      check_val("home_live", powerup_x[31:0], 32'd500);
      wren = 1'b0; addr = 17'd4300; step(1);
      check_val("rd_home", proc_data_in, 32'd500);
      addr = 17'd4205; step(1);
      check_val("rd_p1flag", proc_data_in, 32'd0);

      // Asynchronous reset between edges
      #3 reset = 1'b0;
      #1;
      check_val("arst_flag", {30'd0, powerup_active}, 32'd0);
      check_val("arst_u1x", powerup_x[63:32], 32'd300);
      check_val("arst_u0x", powerup_x[31:0], 32'd300);
      check_val("arst_p0y", player_y[31:0], 32'd100);
      step(1);
      reset = 1'b1;
      step(1);
      check_val("post_rst_flag", {30'd0, powerup_active}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule
